// File: rtl/key_input_pkg.sv
// Shared types and default timing constants for the pushbutton front end.
package key_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  // 20 ms debounce, 0.5 s first repeat, 100 ms repeat period at 50 MHz
  localparam int unsigned KEY_DEBOUNCE_DEFAULT      = 1_000_000;
  localparam int unsigned KEY_REPEAT_DELAY_DEFAULT  = 25_000_000;
  localparam int unsigned KEY_REPEAT_PERIOD_DEFAULT = 5_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: two-flop synchroniser, debounce FSM and strobes.
// Auto-repeat logic exists only when KEY_REPEAT_EN is defined.
//
// state        | meaning
// IDLE         | key released and stable
// PRESS_WAIT   | press seen, counting stable samples
// PRESSED      | key pressed and stable
// RELEASE_WAIT | release seen, counting stable samples
module key_debounce_ch
  import key_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("key_debounce_ch: illegal timing parameters");
  end

  logic             s1_q, s2_q;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= ~key_raw_i;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign press_o   = press_q;
  assign release_o = release_q;

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rcnt_q, rcnt_d;
  logic             repeat_q, repeat_d;

  // Down-counter to the next repeat; only ticks in PRESSED, so it holds in RELEASE_WAIT.
  always_comb begin
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    if (state_q == PRESS_WAIT && state_d == PRESSED) begin
      rcnt_d = RPT_FIRST;
    end else if (state_q == PRESSED) begin
      if (rcnt_q == '0) begin
        repeat_d = 1'b1;
        rcnt_d   = RPT_NEXT;
      end else begin
        rcnt_d = rcnt_q - RPT_ONE;
      end
    end else if (state_q == RELEASE_WAIT && state_d == IDLE) begin
      rcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rcnt_q   <= '0;
      repeat_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/key_input.sv
// Debounced front end for the active-low KEY pushbuttons, one channel per key.
// Define KEY_REPEAT_EN to enable the auto-repeat strobes on key_repeat.
module key_input
  import key_input_pkg::*;
#(
  parameter int unsigned NKEYS           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_repeat
);

  for (genvar i = 0; i < NKEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i    (clk),
      .rst_ni   (rst),
      .key_raw_i(key_raw[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .repeat_o (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_input.sv
// Bench for key_input: directed vector table plus randomized bouncing keys
// checked every cycle against a run-length debounce model.
module tb_key_input;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  localparam logic [3:0] RPT_ALL = REP_EN ? 4'hF : 4'h0;
  localparam logic [3:0] RPT_K0  = REP_EN ? 4'h1 : 4'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_repeat;

  always #5 clk = ~clk;

  key_input #(
    .NKEYS(NK), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_repeat(key_repeat)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Model: synchroniser delay line, accepted level, length of the current
  // run of samples disagreeing with it, and cycles spent stably pressed.
  logic [NK-1:0] m_s1 = '0, m_s2 = '0, m_level = '0;
  logic [NK-1:0] m_press = '0, m_release = '0, m_repeat = '0;
  int m_run[NK];
  int m_held[NK];

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      m_press[k]   = 1'b0;
      m_release[k] = 1'b0;
      m_repeat[k]  = 1'b0;
      if (!rst) begin
        m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_level[k] = 1'b0;
        m_run[k] = 0;   m_held[k] = 0;
      end else begin
        if (m_level[k] && m_run[k] == 0) begin
          m_held[k]++;
          if (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RP == 0))
            m_repeat[k] = REP_EN;
        end
        if (m_s2[k] != m_level[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            m_level[k] = ~m_level[k];
            m_run[k]   = 0;
            if (m_level[k]) begin
              m_press[k] = 1'b1;
              m_held[k]  = 0;
            end else begin
              m_release[k] = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = ~key_raw[k];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle_vs_model", {key_level, key_press, key_release, key_repeat},
          {m_level, m_press, m_release, m_repeat});
    check("press_release_excl", {12'h0, key_press & key_release}, 16'h0);
  endtask

  typedef struct packed {
    logic       rst_n;
    logic [3:0] raw;
    logic [7:0] n;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] raw, input int n,
                              input logic [3:0] l, input logic [3:0] p,
                              input logic [3:0] rl, input logic [3:0] rp);
    vec_t v;
    v.rst_n = r; v.raw = raw; v.n = 8'(n);
    v.lvl = l; v.prs = p; v.rel = rl; v.rpt = rp;
    tbl.push_back(v);
  endfunction

  initial begin
    // reset, then clean press on key 0
    add(0, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 5, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 1, 4'h1, 4'h1, 4'h0, 4'h0);
    add(1, 4'hE, 1, 4'h1, 4'h0, 4'h0, 4'h0);
    // bounce on key 1: low 3, high 2, then held low
    add(1, 4'hC, 3, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 4'hE, 2, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 4'hC, 5, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 4'hC, 1, 4'h3, 4'h2, 4'h0, 4'h0);
    add(1, 4'hC, 1, 4'h3, 4'h0, 4'h0, RPT_K0);
    // clean release of key 0
    add(1, 4'hD, 5, 4'h3, 4'h0, 4'h0, 4'h0);
    add(1, 4'hD, 1, 4'h2, 4'h0, 4'h1, 4'h0);
    add(1, 4'hD, 1, 4'h2, 4'h0, 4'h0, 4'h0);
    // reset while key 2 is in press debounce, keys 1 and 2 held through it
    add(1, 4'h9, 3, 4'h2, 4'h0, 4'h0, 4'h0);
    add(0, 4'h9, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h9, 5, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h9, 1, 4'h6, 4'h6, 4'h0, 4'h0);
    add(1, 4'h9, 1, 4'h6, 4'h0, 4'h0, 4'h0);
    // release all, then all four pressed together and held (repeat)
    add(1, 4'hF, 5, 4'h6, 4'h0, 4'h0, 4'h0);
    add(1, 4'hF, 1, 4'h0, 4'h0, 4'h6, 4'h0);
    add(1, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 1, 4'hF, 4'hF, 4'h0, 4'h0);
    add(1, 4'h0, 1, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 8, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 1, 4'hF, 4'h0, 4'h0, RPT_ALL);
    add(1, 4'h0, 2, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 4'h0, 1, 4'hF, 4'h0, 4'h0, RPT_ALL);
    add(1, 4'h0, 1, 4'hF, 4'h0, 4'h0, 4'h0);

    for (int k = 0; k < NK; k++) begin
      m_run[k]  = 0;
      m_held[k] = 0;
    end

    foreach (tbl[i]) begin
      rst     = tbl[i].rst_n;
      key_raw = tbl[i].raw;
      for (int c = 0; c < int'(tbl[i].n); c++) tick();
      check($sformatf("vec%0d_level", i),   {12'h0, key_level},   {12'h0, tbl[i].lvl});
      check($sformatf("vec%0d_press", i),   {12'h0, key_press},   {12'h0, tbl[i].prs});
      check($sformatf("vec%0d_release", i), {12'h0, key_release}, {12'h0, tbl[i].rel});
      check($sformatf("vec%0d_repeat", i),  {12'h0, key_repeat},  {12'h0, tbl[i].rpt});
    end

    // randomized bouncing with occasional resets, from fast chatter to long holds
    for (int seg = 0; seg < 3; seg++) begin
      int odds;
      odds = (seg == 0) ? 3 : (seg == 1) ? 8 : 25;
      for (int c = 0; c < 700; c++) begin
        for (int k = 0; k < NK; k++)
          if ($urandom_range(odds - 1) == 0) key_raw[k] = ~key_raw[k];
        rst = ($urandom_range(299) != 0);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
